// File: rtl/if_id_pipe_buffer.sv
// IF/ID elastic buffer: DEPTH-entry queue between fetch and decode that presents
// the head instruction pre-split into MIPS fields, or a zero bubble when empty.
module if_id_pipe_buffer #(
    parameter int  PC_W  = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ReadInst,
    input  logic [PC_W-1:0] IF_PC_Plus_4,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      OpCode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      Shamt,
    output logic [5:0]      Funct,
    output logic [PC_W-1:0] PC_Plus_4,
    output logic [CW-1:0]   occupancy
);

    localparam int            SLOTS = 1 << PW;
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    logic [31:0]     inst_mem_q [SLOTS];
    logic [PC_W-1:0] pc_mem_q   [SLOTS];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [31:0]     head_inst;
    logic [PC_W-1:0] head_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake: a word moves on a side only in a cycle where valid & ready are both
    // high at the rising edge and flush is low; in_ready comes from count alone.
    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign occupancy = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; it is only observable while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= ReadInst;
            pc_mem_q[wr_ptr_q]   <= IF_PC_Plus_4;
        end
    end

    assign head_inst = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign head_pc   = out_valid ? pc_mem_q[rd_ptr_q]   : '0;

    assign OpCode    = head_inst[31:26];
    assign rs        = head_inst[25:21];
    assign rt        = head_inst[20:16];
    assign rd        = head_inst[15:11];
    assign Shamt     = head_inst[10:6];
    assign Funct     = head_inst[5:0];
    assign PC_Plus_4 = head_pc;

    a_count_ok: assert property (@(posedge clk) disable iff (!reset)
        (count_q <= FULL) &&
        ((count_q == '0) == ((rd_ptr_q == wr_ptr_q) && (count_q != FULL))));

endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Bench for if_id_pipe_buffer: three instances (DEPTH 2, 3, 1) checked with a
// vector table for directed cycles and a queue scoreboard for streamed traffic.
module tb_if_id_pipe_buffer;

    logic clk;
    logic rst_n;

    logic        iv_a   [3];
    logic        ordy_a [3];
    logic        fl_a   [3];
    logic [31:0] inst_a [3];
    logic [31:0] pc_a   [3];

    wire         ir_a   [3];
    wire         ov_a   [3];
    wire  [5:0]  op_a   [3];
    wire  [4:0]  rs_a   [3];
    wire  [4:0]  rt_a   [3];
    wire  [4:0]  rd_a   [3];
    wire  [4:0]  sh_a   [3];
    wire  [5:0]  fn_a   [3];
    wire  [31:0] pco_a  [3];
    wire  [1:0]  occ0;
    wire  [1:0]  occ1;
    wire  [0:0]  occ2;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    if_id_pipe_buffer #(.PC_W(32), .DEPTH(2)) dut_d2 (
        .clk(clk), .reset(rst_n), .flush(fl_a[0]),
        .in_valid(iv_a[0]), .in_ready(ir_a[0]),
        .ReadInst(inst_a[0]), .IF_PC_Plus_4(pc_a[0]),
        .out_valid(ov_a[0]), .out_ready(ordy_a[0]),
        .OpCode(op_a[0]), .rs(rs_a[0]), .rt(rt_a[0]), .rd(rd_a[0]),
        .Shamt(sh_a[0]), .Funct(fn_a[0]), .PC_Plus_4(pco_a[0]),
        .occupancy(occ0)
    );

    if_id_pipe_buffer #(.PC_W(32), .DEPTH(3)) dut_d3 (
        .clk(clk), .reset(rst_n), .flush(fl_a[1]),
        .in_valid(iv_a[1]), .in_ready(ir_a[1]),
        .ReadInst(inst_a[1]), .IF_PC_Plus_4(pc_a[1]),
        .out_valid(ov_a[1]), .out_ready(ordy_a[1]),
        .OpCode(op_a[1]), .rs(rs_a[1]), .rt(rt_a[1]), .rd(rd_a[1]),
        .Shamt(sh_a[1]), .Funct(fn_a[1]), .PC_Plus_4(pco_a[1]),
        .occupancy(occ1)
    );

    if_id_pipe_buffer #(.PC_W(32), .DEPTH(1)) dut_d1 (
        .clk(clk), .reset(rst_n), .flush(fl_a[2]),
        .in_valid(iv_a[2]), .in_ready(ir_a[2]),
        .ReadInst(inst_a[2]), .IF_PC_Plus_4(pc_a[2]),
        .out_valid(ov_a[2]), .out_ready(ordy_a[2]),
        .OpCode(op_a[2]), .rs(rs_a[2]), .rt(rt_a[2]), .rd(rd_a[2]),
        .Shamt(sh_a[2]), .Funct(fn_a[2]), .PC_Plus_4(pco_a[2]),
        .occupancy(occ2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic int depth_of(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] occ_of(input int k);
        case (k)
            0:       return {1'b0, occ0};
            1:       return {1'b0, occ1};
            default: return {2'b00, occ2};
        endcase
    endfunction

    function automatic logic [31:0] head_of(input int k);
        return {op_a[k], rs_a[k], rt_a[k], rd_a[k], sh_a[k], fn_a[k]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver + scoreboard step ----------------
    // At the falling edge: compare outputs with the model, then drive the inputs
    // for the next rising edge and advance the model accordingly.
    task automatic step(input int k, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic ordy, input logic fl,
                        output logic acc);
        logic e_ir, e_ov;
        @(negedge clk);
        e_ir = (exp_q.size() < depth_of(k));
        e_ov = (exp_q.size() != 0);
        chk("in_ready", 64'(ir_a[k]), 64'(e_ir));
        chk("out_valid", 64'(ov_a[k]), 64'(e_ov));
        chk("occupancy", 64'(occ_of(k)), 64'(exp_q.size()));
        if (e_ov) begin
            chk("head_inst", 64'(head_of(k)), 64'(exp_q[0][31:0]));
            chk("head_pc", 64'(pco_a[k]), 64'(exp_q[0][63:32]));
        end else begin
            chk("bubble_inst", 64'(head_of(k)), 64'(0));
            chk("bubble_pc", 64'(pco_a[k]), 64'(0));
        end
        iv_a[k]   = iv;
        inst_a[k] = inst;
        pc_a[k]   = pc;
        ordy_a[k] = ordy;
        fl_a[k]   = fl;
        acc = iv && e_ir && !fl;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (e_ov && ordy) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({pc, inst});
        end
    endtask

    // Streams n random words; an offered word is held until accepted.
    task automatic run_stream(input int k, input int n, input int rdy_pct,
                              input int val_pct, input int rdy_start,
                              input int flush_pct, input int budget);
        int pushed = 0;
        int cyc = 0;
        logic pending = 1'b0;
        logic acc, iv, ordy, fl;
        logic [31:0] w_inst = $urandom;
        logic [31:0] w_pc = 32'h100;
        while ((pushed < n || exp_q.size() != 0) && cyc < budget) begin
            iv   = (pushed < n) && (pending || ($urandom_range(1, 100) <= val_pct));
            ordy = (cyc >= rdy_start) && ($urandom_range(1, 100) <= rdy_pct);
            fl   = (flush_pct != 0) && ($urandom_range(1, 100) <= flush_pct);
            step(k, iv, iv ? w_inst : 32'h0, iv ? w_pc : 32'h0, ordy, fl, acc);
            if (acc) begin
                pushed++;
                pending = 1'b0;
                w_inst  = $urandom;
                w_pc    = w_pc + 32'd4;
            end else if (iv) begin
                pending = 1'b1;
            end
            cyc++;
        end
        chk("stream_done_in_budget", 64'(cyc < budget), 64'(1));
        step(k, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    endtask

    // ---------------- directed vector table (DEPTH=2) ----------------
    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic acc;
        for (int k = 0; k < 3; k++) begin
            iv_a[k] = 1'b0; ordy_a[k] = 1'b0; fl_a[k] = 1'b0;
            inst_a[k] = '0; pc_a[k] = '0;
        end

        // Each row: outputs expected at this falling edge, then inputs driven.
        vecs[0] = '{1'b1, 32'h8C220004, 32'h04, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00};
        vecs[1] = '{1'b1, 32'h00221820, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h8C220004, 32'h04};
        vecs[2] = '{1'b0, 32'h0,        32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h00221820, 32'h08};
        vecs[3] = '{1'b1, 32'h00021080, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00};
        vecs[4] = '{1'b1, 32'h3C01ABCD, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h00021080, 32'h0C};
        vecs[5] = '{1'b1, 32'hAC430008, 32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h00021080, 32'h0C};
        vecs[6] = '{1'b1, 32'h20420001, 32'h18, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00};
        vecs[7] = '{1'b0, 32'h0,        32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00};
        vecs[8] = '{1'b1, 32'h00221820, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00};
        vecs[9] = '{1'b0, 32'h0,        32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h00221820, 32'h1C};

        apply_reset();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 64'(ov_a[0]), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 64'(ir_a[0]), 64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_occupancy", i), 64'(occ0), 64'(vecs[i].e_occ));
            chk($sformatf("vec%0d_head_inst", i), 64'(head_of(0)), 64'(vecs[i].e_inst));
            chk($sformatf("vec%0d_head_pc", i), 64'(pco_a[0]), 64'(vecs[i].e_pc));
            iv_a[0]   = vecs[i].iv;
            inst_a[0] = vecs[i].inst;
            pc_a[0]   = vecs[i].pc;
            ordy_a[0] = vecs[i].ordy;
            fl_a[0]   = vecs[i].fl;
        end
        // Row 9 popped the last word; settle back to empty.
        exp_q.delete();
        step(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // Field split of the lw word, named individually.
        step(0, 1'b1, 32'h8C220004, 32'h04, 1'b0, 1'b0, acc);
        @(negedge clk);
        chk("lw_opcode", 64'(op_a[0]), 64'h23);
        chk("lw_rs", 64'(rs_a[0]), 64'd1);
        chk("lw_rt", 64'(rt_a[0]), 64'd2);
        chk("lw_funct", 64'(fn_a[0]), 64'h04);

        // Asynchronous reset mid-traffic: fill to full, then reset between edges.
        iv_a[0] = 1'b1; inst_a[0] = 32'h00221820; pc_a[0] = 32'h08;
        @(negedge clk);
        iv_a[0] = 1'b1; inst_a[0] = 32'h3C01ABCD; pc_a[0] = 32'h0C;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(ov_a[0]), 64'(0));
        chk("rst_in_ready", 64'(ir_a[0]), 64'(1));
        chk("rst_occupancy", 64'(occ0), 64'(0));
        chk("rst_fields", 64'(head_of(0)), 64'(0));
        chk("rst_pc", 64'(pco_a[0]), 64'(0));
        iv_a[0] = 1'b0; inst_a[0] = '0; pc_a[0] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();

        // Backpressure: three words offered while decode stalls, then drained.
        run_stream(0, 3, 100, 100, 5, 0, 40);
        // Wrap with a non-power-of-2 depth and random decode readiness.
        run_stream(1, 10, 50, 80, 0, 0, 200);
        // Single entry, both sides always ready: half throughput.
        run_stream(2, 8, 100, 100, 0, 0, 40);
        // Mixed random traffic with occasional flushes.
        run_stream(0, 40, 60, 70, 0, 5, 600);
        run_stream(1, 30, 40, 90, 0, 4, 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
